if_id_stage: RTL
================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter DW, default 8: instruction/immediate byte width; opcode = bits [DW-1:DW-4], brx = bits [DW-5:DW-6].
REQ-002 SHALL have parameter AW, default 8: program counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_in  input  DW  memory byte fetched at pc_in.
REQ-006 SHALL have port pc_in  input  AW  address of instr_in.
REQ-007 SHALL have port fetch_valid  input  1  fetch unit presents a new byte this cycle.
REQ-008 SHALL have port stall  input  1  freeze the stage.
REQ-009 SHALL have port flush  input  1  branch/redirect; discard stage contents.
REQ-010 SHALL have port intr  input  1  interrupt entry; treated as flush.
REQ-011 SHALL have port instr_out  output  DW  latched first instruction byte.
REQ-012 SHALL have port imm_out  output  DW  latched second byte (LDM/LDD/STD).
REQ-013 SHALL have port pc_out  output  AW  address of first byte.
REQ-014 SHALL have port pc_next_out  output  AW  address after the complete instruction (CALL return address).
REQ-015 SHALL have port id_valid  output  1  decode holds a complete instruction; 0 = bubble.
REQ-016 SHALL have port imm_pending  output  1  first byte of a two-byte instruction held, awaiting immediate.
REQ-017 SHALL have port opcode_out  output  4  instr_out opcode field, combinational from register.
REQ-018 SHALL have port brx_out  output  2  instr_out brx field, combinational from register.
REQ-019 SHALL have port bubble_cnt  output  16  bubble performance counter.

Function
REQ-020 SHALL define cap = fetch_valid & !stall & !flush & !intr.
REQ-021 SHALL implement states S_EMPTY, S_HOLD and S_IMM.
REQ-022 In S_EMPTY or S_HOLD with cap and a one-byte opcode (not 4'd12), SHALL, at the next edge, latch instr_out<=instr_in, pc_out<=pc_in, pc_next_out<=pc_in+1, set id_valid<=1 and go to S_HOLD.
REQ-023 In S_EMPTY or S_HOLD with cap and opcode 4'd12, SHALL latch instr_out and pc_out, set id_valid<=0 and imm_pending<=1, and go to S_IMM.
REQ-024 In S_IMM with cap, SHALL latch imm_out<=instr_in and pc_next_out<=pc_in+1, set id_valid<=1 and imm_pending<=0, go to S_HOLD, and leave instr_out/pc_out unchanged.
REQ-025 With no cap, !stall and !flush/!intr, SHALL set id_valid<=0; S_HOLD goes to S_EMPTY and S_IMM stays in S_IMM.
REQ-026 With stall and no flush/intr, SHALL hold every register, including id_valid and state.
REQ-027 With flush or intr, SHALL set id_valid<=0, imm_pending<=0 and instr_out<=0 and go to S_EMPTY; this has priority over stall and fetch_valid, and the byte presented in that cycle is discarded.
REQ-028 SHALL compute pc+1 modulo 2^AW (8'hFF -> 8'h00).
REQ-029 SHALL have a capture-to-output latency of exactly one cycle, with no combinational path from any input to any output.

Reset
REQ-030 On reset low, SHALL immediately clear instr_out, imm_out, pc_out, pc_next_out, id_valid, imm_pending and bubble_cnt to 0 and set state to S_EMPTY, regardless of clk.
REQ-031 Reset asserted mid-S_IMM SHALL abandon the partial instruction.

Configuration
REQ-032 With macro IFID_BUBBLE_CNT_EN defined, bubble_cnt SHALL increment by 1 on each edge where id_valid will be 0 and stall is 0, saturating at 16'hFFFF.
REQ-033 Without IFID_BUBBLE_CNT_EN, bubble_cnt SHALL be constant 0, the port SHALL remain present, and no counter flops SHALL be inferred.

Structure
REQ-034 Shared package SHALL hold OP_TWO_BYTE = 4'd12, the state encoding for S_EMPTY/S_HOLD/S_IMM, and the default DW/AW widths.
REQ-035 The bubble counter SHALL be sub-module ifid_bubble_counter (enable, clear, 16-bit saturating), instantiated only under IFID_BUBBLE_CNT_EN.

Verification
REQ-036 Reset, then 0x40 at pc 0x10 with fetch_valid -> next cycle: id_valid=1, instr_out=0x40, pc_out=0x10, pc_next_out=0x11, opcode_out=4.
REQ-037 0xC4 at 0x20, then 0x5A at 0x21 -> after edge 1: id_valid=0, imm_pending=1; after edge 2: id_valid=1, instr_out=0xC4, imm_out=0x5A, pc_out=0x20, pc_next_out=0x22.
REQ-038 Holding 0x40 valid, stall=1 for 3 cycles with new bytes offered -> outputs unchanged; bubble_cnt unchanged.
REQ-039 In S_IMM, flush=1 and stall=1 together -> next cycle: id_valid=0, imm_pending=0, instr_out=0x00; a following 0x5A is treated as a new first byte.
REQ-040 0x31 at pc 0xFF -> pc_next_out=0x00, id_valid=1.
REQ-041 Reset low mid-S_IMM, between edges -> all outputs 0 before the next edge; with IFID_BUBBLE_CNT_EN, 5 idle cycles -> bubble_cnt=5.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline stage.
//   OP_TWO_BYTE : opcode of instructions that carry an immediate byte
//   state_t     : capture FSM encoding (S_EMPTY / S_HOLD / S_IMM)
//   DEF_DW/AW   : default instruction and program-counter widths
//   BUB_CNT_W   : width of the bubble performance counter
package if_id_stage_pkg;

  localparam logic [3:0] OP_TWO_BYTE = 4'd12;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 8;
  localparam int BUB_CNT_W = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_IMM   = 2'd2
  } state_t;

endpackage

// File: rtl/ifid_bubble_counter.sv
// Saturating bubble performance counter for the IF/ID stage.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset (clears the count)
//   enable : count one bubble this edge
//   clear  : synchronous clear, wins over enable
//   cnt    : current count, sticks at all-ones
module ifid_bubble_counter
  import if_id_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  output logic [BUB_CNT_W-1:0] cnt
);

  logic [BUB_CNT_W-1:0] cnt_r;

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {BUB_CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {BUB_CNT_W{1'b0}};
    end else if (enable && (cnt_r != {BUB_CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(BUB_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with two-byte instruction assembly.
// Captures one-byte instructions directly; for opcode OP_TWO_BYTE the first
// byte is held (imm_pending) until the immediate byte arrives. Stall freezes
// everything, flush/intr empty the stage and win over stall and fetch.
// Every output is driven straight from a flop (opcode/brx are fields of one).
//   clk, reset              : clock, async active-low reset
//   instr_in, pc_in         : fetched byte and its address
//   fetch_valid, stall      : fetch handshake / freeze
//   flush, intr             : redirect / interrupt entry (both empty the stage)
//   instr_out, imm_out      : first byte and immediate byte
//   pc_out, pc_next_out     : first-byte address, address after the instruction
//   id_valid, imm_pending   : complete instruction held / waiting for immediate
//   opcode_out, brx_out     : fields of instr_out
//   bubble_cnt              : bubble counter; only counts when the build
//                             defines IFID_BUBBLE_CNT_EN, otherwise constant 0
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] instr_in,
  input  logic [AW-1:0] pc_in,
  input  logic          fetch_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic          intr,
  output logic [DW-1:0] instr_out,
  output logic [DW-1:0] imm_out,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_next_out,
  output logic          id_valid,
  output logic          imm_pending,
  output logic [3:0]    opcode_out,
  output logic [1:0]    brx_out,
  output logic [15:0]   bubble_cnt
);

  state_t        state_r, state_s;
  logic [DW-1:0] instr_r, instr_s;
  logic [DW-1:0] imm_r, imm_s;
  logic [AW-1:0] pc_r, pc_s;
  logic [AW-1:0] pcn_r, pcn_s;
  logic          valid_r, valid_s;
  logic          pend_r, pend_s;
  logic [3:0]    in_op_s;
  logic [AW-1:0] pc_inc_s;

  assign in_op_s  = instr_in[DW-1 -: 4];
  // Natural AW-bit wrap gives pc+1 modulo 2^AW.
  assign pc_inc_s = pc_in + {{(AW-1){1'b0}}, 1'b1};

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_s = state_r;
    instr_s = instr_r;
    imm_s   = imm_r;
    pc_s    = pc_r;
    pcn_s   = pcn_r;
    valid_s = valid_r;
    pend_s  = pend_r;
    if (flush || intr) begin
      // Redirect: discard held bytes and whatever is offered this cycle.
      state_s = S_EMPTY;
      instr_s = {DW{1'b0}};
      valid_s = 1'b0;
      pend_s  = 1'b0;
    end else if (stall) begin
      state_s = state_r;
    end else if (fetch_valid) begin
      case (state_r)
        S_EMPTY, S_HOLD: begin
          instr_s = instr_in;
          pc_s    = pc_in;
          if (in_op_s == OP_TWO_BYTE) begin
            valid_s = 1'b0;
            pend_s  = 1'b1;
            state_s = S_IMM;
          end else begin
            pcn_s   = pc_inc_s;
            valid_s = 1'b1;
            state_s = S_HOLD;
          end
        end
        S_IMM: begin
          // Immediate byte completes the instruction; first byte untouched.
          imm_s   = instr_in;
          pcn_s   = pc_inc_s;
          valid_s = 1'b1;
          pend_s  = 1'b0;
          state_s = S_HOLD;
        end
        default: begin
          valid_s = 1'b0;
          pend_s  = 1'b0;
          state_s = S_EMPTY;
        end
      endcase
    end else begin
      // Nothing offered: bubble. A half-assembled instruction keeps waiting.
      valid_s = 1'b0;
      case (state_r)
        S_HOLD:  state_s = S_EMPTY;
        S_IMM:   state_s = S_IMM;
        S_EMPTY: state_s = S_EMPTY;
        default: state_s = S_EMPTY;
      endcase
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_EMPTY;
      instr_r <= {DW{1'b0}};
      imm_r   <= {DW{1'b0}};
      pc_r    <= {AW{1'b0}};
      pcn_r   <= {AW{1'b0}};
      valid_r <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      instr_r <= instr_s;
      imm_r   <= imm_s;
      pc_r    <= pc_s;
      pcn_r   <= pcn_s;
      valid_r <= valid_s;
      pend_r  <= pend_s;
    end
  end

  assign instr_out   = instr_r;
  assign imm_out     = imm_r;
  assign pc_out      = pc_r;
  assign pc_next_out = pcn_r;
  assign id_valid    = valid_r;
  assign imm_pending = pend_r;
  assign opcode_out  = instr_r[DW-1 -: 4];
  assign brx_out     = instr_r[DW-5 -: 2];

`ifdef IFID_BUBBLE_CNT_EN
  logic bub_en_s;
  // A bubble is an edge that leaves decode empty while the pipe is moving.
  assign bub_en_s = ~valid_s & ~stall;

  ifid_bubble_counter u_bubble_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (bub_en_s),
    .clear  (1'b0),
    .cnt    (bubble_cnt)
  );
`else
  assign bubble_cnt = 16'd0;
`endif

endmodule
